// File: rtl/lsu_ctrl_pkg.sv
// Shared types for the load/store unit controller: access sizes, error codes
// and FSM states.
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_ILLEGAL  = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic logic is_misaligned(size_e size, logic [1:0] addr_lo);
    return ((size == SIZE_H) && addr_lo[0]) ||
           ((size == SIZE_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory bus port: valid/ready request channel plus response strobe.
interface lsu_ctrl_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/lsu_ctrl_load_align.sv
// Load path: selects the addressed byte/half of the read word and extends it.
module load_align
  import lsu_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_B:  result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SIZE_H:  result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl_store_gen.sv
// Store path: places the source register into its byte lanes and builds strobes.
module store_gen
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]  store_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb
);

  always_comb begin
    wdata = '0;
    wstrb = '0;
    case (size_e'(store_type))
      SIZE_B: begin
        wdata = {24'b0, rs2[7:0]} << {addr_lo, 3'b000};
        wstrb = 4'b0001 << addr_lo;
      end
      SIZE_H: begin
        wdata = {16'b0, rs2[15:0]} << {addr_lo[1], 4'b0000};
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SIZE_W: begin
        wdata = rs2;
        wstrb = '1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: checks the access, runs one bus transaction with
// timeout and returns extended load data or an error code to the pipeline.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_W           = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  lsu_ctrl_if.master  mem,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [1:0]  alo_q, alo_d;
  size_e       size_q, size_d;
  logic        uns_q, uns_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  err_e        err_q, err_d;

  logic        accept, timeout_hit, mem_req_valid_o;
  err_e        chk_err;
  logic [31:0] sg_wdata, ld_data;
  logic [3:0]  sg_wstrb;

  store_gen u_store_gen (
    .store_type (req_size),
    .addr_lo    (req_addr[1:0]),
    .rs2        (req_wdata),
    .wdata      (sg_wdata),
    .wstrb      (sg_wstrb)
  );

  load_align u_load_align (
    .rdata       (mem.mem_rdata),
    .addr_lo     (alo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (ld_data)
  );

  assign accept = req_valid && (state_q == ST_IDLE);
  // Illegal size is checked first so it wins over misalignment.
  assign chk_err = (size_e'(req_size) == SIZE_X) ? ERR_ILLEGAL :
                   is_misaligned(size_e'(req_size), req_addr[1:0]) ? ERR_MISALIGN :
                   ERR_NONE;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (chk_err == ERR_NONE) ? ST_REQ : ST_RESP;
      ST_REQ:  if (mem.mem_req_ready) state_d = ST_WAIT;
      ST_WAIT: if (mem.mem_rsp_valid || timeout_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready       = (state_q == ST_IDLE);
    mem_req_valid_o = (state_q == ST_REQ);
    rsp_valid       = (state_q == ST_RESP);
    busy            = (state_q != ST_IDLE);
  end

  always_comb begin
    alo_d   = alo_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    rdata_d = '0;
    err_d   = ERR_NONE;
    case (state_q)
      ST_IDLE: if (accept) begin
        alo_d   = req_addr[1:0];
        size_d  = size_e'(req_size);
        uns_d   = req_unsigned;
        we_d    = req_we;
        addr_d  = {req_addr[31:2], 2'b00};
        wdata_d = req_we ? sg_wdata : '0;
        wstrb_d = req_we ? sg_wstrb : '0;
        err_d   = chk_err;
      end
      ST_REQ: if (mem.mem_req_ready) cnt_d = '0;
      ST_WAIT: begin
        cnt_d = cnt_q + TO_W'(1);
        if (mem.mem_rsp_valid) rdata_d = we_q ? '0 : ld_data;
        else if (timeout_hit)  err_d   = ERR_TIMEOUT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alo_q   <= '0;
      size_q  <= SIZE_B;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      alo_q   <= alo_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem.mem_req_valid = mem_req_valid_o;
  assign mem.mem_addr      = addr_q;
  assign mem.mem_we        = we_q;
  assign mem.mem_wdata     = wdata_q;
  assign mem.mem_wstrb     = wstrb_q;
  assign rsp_rdata         = rdata_q;
  assign rsp_err           = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed cases plus random accesses against a reference
// model built from the access rules (lane shifts, extension, timeout count).
module tb_lsu_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        busy;

  int checks = 0;
  int failures = 0;

  lsu_ctrl_if bus ();

  lsu_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .mem          (bus),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] m_err(logic [1:0] size, logic [31:0] addr);
    if (size == 2'd3) return 2'd2;
    if (size == 2'd1 && addr[0]) return 2'd1;
    if (size == 2'd2 && addr[1:0] != 2'd0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] m_strb(logic [1:0] size, logic [1:0] a);
    if (size == 2'd0) return 4'b0001 << a;
    if (size == 2'd1) return 4'b0011 << a;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(logic [1:0] size, logic [1:0] a, logic [31:0] d);
    int unsigned sh = 8 * a;
    if (size == 2'd0) return (d & 32'h0000_00FF) << sh;
    if (size == 2'd1) return (d & 32'h0000_FFFF) << sh;
    return d;
  endfunction

  function automatic logic [31:0] m_load(logic [1:0] size, logic [1:0] a, logic uns, logic [31:0] rd);
    int unsigned sh = 8 * a;
    logic [31:0] v = rd >> sh;
    if (size == 2'd0) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Presents one request at a negedge and returns at the negedge after acceptance.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd, input string tag);
    chk({tag, ".req_ready"}, req_ready, 1);
    chk({tag, ".busy_idle"}, busy, 0);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd, input int rdy_dly,
                        input int rsp_dly, input logic [31:0] rd, input string tag);
    logic [1:0] e = m_err(size, addr);
    logic       tmo = (rsp_dly >= int'(TO));
    logic [1:0] a = addr[1:0];
    issue(we, addr, size, uns, wd, tag);
    if (e != 2'd0) begin
      chk({tag, ".err_rsp_valid"}, rsp_valid, 1);
      chk({tag, ".err_code"}, rsp_err, e);
      chk({tag, ".err_rdata"}, rsp_rdata, 0);
      chk({tag, ".err_no_bus"}, bus.mem_req_valid, 0);
      @(negedge clk);
      chk({tag, ".err_rsp_drop"}, rsp_valid, 0);
      chk({tag, ".err_ready_back"}, req_ready, 1);
      return;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      chk({tag, ".mem_req_valid"}, bus.mem_req_valid, 1);
      chk({tag, ".mem_addr"}, bus.mem_addr, addr & 32'hFFFF_FFFC);
      chk({tag, ".mem_we"}, bus.mem_we, we);
      chk({tag, ".mem_wstrb"}, bus.mem_wstrb, we ? m_strb(size, a) : 4'b0);
      chk({tag, ".mem_wdata"}, bus.mem_wdata, we ? m_wdata(size, a, wd) : 32'h0);
      chk({tag, ".busy_req"}, busy, 1);
      chk({tag, ".ready_req"}, req_ready, 0);
      bus.mem_rsp_valid = 1'($urandom_range(0, 1));
      bus.mem_req_ready = (i == rdy_dly);
      @(negedge clk);
    end
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    chk({tag, ".req_drop"}, bus.mem_req_valid, 0);
    for (int k = 0; k < int'(TO); k++) begin
      if (k == rsp_dly) begin
        bus.mem_rsp_valid = 1'b1; bus.mem_rdata = rd;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0; bus.mem_rdata = $urandom;
        break;
      end
      chk({tag, ".wait_no_rsp"}, rsp_valid, 0);
      chk({tag, ".wait_busy"}, busy, 1);
      @(negedge clk);
    end
    chk({tag, ".rsp_valid"}, rsp_valid, 1);
    chk({tag, ".rsp_err"}, rsp_err, tmo ? 2'd3 : 2'd0);
    chk({tag, ".rsp_rdata"}, rsp_rdata, (tmo || we) ? 32'h0 : m_load(size, a, uns, rd));
    chk({tag, ".busy_resp"}, busy, 1);
    @(negedge clk);
    chk({tag, ".rsp_pulse"}, rsp_valid, 0);
    chk({tag, ".rsp_rdata_clr"}, rsp_rdata, 0);
    chk({tag, ".rsp_err_clr"}, rsp_err, 0);
    chk({tag, ".idle_ready"}, req_ready, 1);
  endtask

  initial begin
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata = '0;
    #12;
    chk("reset.req_ready", req_ready, 1);
    chk("reset.busy", busy, 0);
    chk("reset.mem_req_valid", bus.mem_req_valid, 0);
    chk("reset.mem_addr", bus.mem_addr, 0);
    chk("reset.mem_wdata", bus.mem_wdata, 0);
    chk("reset.mem_wstrb", bus.mem_wstrb, 0);
    chk("reset.rsp_valid", rsp_valid, 0);
    chk("reset.rsp_err", rsp_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    access(1'b1, 32'h1000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, 0, 32'h0, "sw");
    access(1'b1, 32'h0000_0003, 2'd0, 1'b0, 32'h0000_00A5, 0, 0, 32'h0, "sb");
    access(1'b0, 32'h2000_0002, 2'd0, 1'b0, 32'h0, 0, 0, 32'h1280_3456, "lb");
    access(1'b0, 32'h2000_0002, 2'd0, 1'b1, 32'h0, 0, 0, 32'h1280_3456, "lbu");
    access(1'b0, 32'h2000_0002, 2'd1, 1'b0, 32'h0, 1, 1, 32'h8001_7FFF, "lh_hi");
    access(1'b0, 32'h2000_0001, 2'd1, 1'b0, 32'h0, 0, 0, 32'h0, "lh_mis");
    access(1'b1, 32'h2000_0003, 2'd3, 1'b0, 32'h1234_5678, 0, 0, 32'h0, "size3");
    access(1'b1, 32'h3000_0002, 2'd1, 1'b0, 32'hCAFE_F00D, 5, 2, 32'h0, "stall");
    access(1'b0, 32'h4000_0000, 2'd2, 1'b0, 32'h0, 0, int'(TO) - 1, 32'h89AB_CDEF, "last_cycle_rsp");
    access(1'b0, 32'h4000_0008, 2'd2, 1'b0, 32'h0, 0, 99, 32'h0, "timeout");

    bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    chk("late_rsp.rsp_valid", rsp_valid, 0);
    chk("late_rsp.busy", busy, 0);
    @(negedge clk);
    chk("late_rsp.rsp_valid2", rsp_valid, 0);

    issue(1'b0, 32'h5000_0000, 2'd2, 1'b0, 32'h0, "rst_req");
    chk("rst_req.pre_valid", bus.mem_req_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_req.mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_req.mem_addr", bus.mem_addr, 0);
    chk("rst_req.req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b1, 32'h6000_0004, 2'd2, 1'b0, 32'h5555_AAAA, "rst_wait");
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_wait.mem_we", bus.mem_we, 0);
    chk("rst_wait.mem_wdata", bus.mem_wdata, 0);
    chk("rst_wait.mem_wstrb", bus.mem_wstrb, 0);
    chk("rst_wait.busy", busy, 0);
    chk("rst_wait.rsp_valid", rsp_valid, 0);
    bus.mem_rsp_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_wait.no_rsp", rsp_valid, 0);
      @(negedge clk);
    end

    for (int n = 0; n < 60; n++) begin
      int unsigned r = $urandom_range(0, 9);
      logic [1:0]  sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      logic [31:0] ad = $urandom;
      if ($urandom_range(0, 3) != 0) ad = ad & ((sz == 2'd1) ? 32'hFFFF_FFFE :
                                               (sz == 2'd2) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
      access(1'($urandom_range(0, 1)), ad, sz, 1'($urandom_range(0, 1)), $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), $urandom, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
